// File: rtl/acc_seq_ctrl_pkg.sv
// rtl/acc_seq_ctrl_pkg.sv - shared state encoding and default widths for the accumulator sequencer
package acc_seq_pkg;

  localparam int DEF_PSUM_W = 20;
  localparam int DEF_ACC_W  = 36;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// rtl/acc_seq_ctrl_if.sv - partial-sum input stream and result output stream of the sequencer
interface acc_seq_ctrl_if #(
  parameter int PSUM_W = acc_seq_pkg::DEF_PSUM_W,
  parameter int ACC_W  = acc_seq_pkg::DEF_ACC_W
) ();

  logic              psum_valid;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum_data;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  // master: the sequencer (consumes psums, produces results)
  modport master (
    input  psum_valid, psum_data, res_ready,
    output psum_ready, res_valid, res_data
  );

  // slave: the adder tree / downstream side
  modport slave (
    output psum_valid, psum_data, res_ready,
    input  psum_ready, res_valid, res_data
  );

endinterface

// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - sequences psum accumulation for one job and hands the final sum downstream
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  acc_seq_ctrl_if.master    bus,
  output logic [PSUM_W-1:0] acc_in1,
  output logic              acc_st,
  output logic              acc_en,
  input  logic [ACC_W-1:0]  acc_nout,
  output logic              busy
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   count, count_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic               ready_c;
  logic [PSUM_W-1:0]  in1_c;
  logic               st_c;
  logic               en_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      count <= '0;
      res_q <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
      res_q <= res_d;
    end
  end

  // Outside ACC the accumulator is held in clear so every job starts from zero.
  always_comb begin
    state_d = state;
    count_d = count;
    res_d   = res_q;
    ready_c = 1'b0;
    in1_c   = '0;
    st_c    = 1'b1;
    en_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            count_d = len;
            state_d = ACC;
          end else begin
            res_d   = '0;
            state_d = OUT;
          end
        end
      end
      ACC: begin
        ready_c = 1'b1;
        st_c    = 1'b0;
        en_c    = 1'b1;
        // A stall feeds zero so the stored sum is simply re-registered.
        if (bus.psum_valid) begin
          in1_c   = bus.psum_data;
          count_d = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            res_d   = acc_nout;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.psum_ready = ready_c;
  assign bus.res_valid  = (state == OUT);
  assign bus.res_data   = res_q;
  assign acc_in1        = in1_c;
  assign acc_st         = st_c;
  assign acc_en         = en_c;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb/tb_acc_seq_ctrl.sv - directed scoreboard bench for acc_seq_ctrl with a behavioural accumulator
module tb_acc_seq_ctrl;
  import acc_seq_pkg::*;

  localparam int PSUM_W = DEF_PSUM_W;
  localparam int ACC_W  = DEF_ACC_W;
  localparam int CNT_W  = DEF_CNT_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [PSUM_W-1:0] acc_in1;
  logic              acc_st;
  logic              acc_en;
  logic [ACC_W-1:0]  acc_nout;
  logic              busy;
  logic [ACC_W-1:0]  acc_reg;

  acc_seq_ctrl_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

  acc_seq_ctrl #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .len      (len),
    .bus      (bus),
    .acc_in1  (acc_in1),
    .acc_st   (acc_st),
    .acc_en   (acc_en),
    .acc_nout (acc_nout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Accumulator: sign-extended in1 plus (optionally) the stored value; st clears the register.
  assign acc_nout = {{(ACC_W-PSUM_W){acc_in1[PSUM_W-1]}}, acc_in1} + (acc_en ? acc_reg : '0);
  always @(posedge clk) begin
    if (!rstn || acc_st) acc_reg <= '0;
    else                 acc_reg <= acc_nout;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [ACC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %0h expected no result", bus.res_data);
      end else begin
        check("res_data", 64'(bus.res_data), 64'(exp_q[0]));
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic psum(input logic v, input logic [PSUM_W-1:0] d);
    bus.psum_valid = v;
    bus.psum_data  = d;
    #1;
  endtask

  logic              gap_v [7];
  logic [PSUM_W-1:0] gap_d [7];

  initial begin
    gap_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gap_d = '{20'h1, 20'h55555, 20'h55555, 20'h2, 20'h3, 20'h55555, 20'h4};
    rstn = 1'b0; start = 1'b0; len = '0;
    bus.psum_valid = 1'b0; bus.psum_data = '0; bus.res_ready = 1'b1;
    tick(); tick();
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_psum_ready", 64'(bus.psum_ready), 64'd0);
    check("rst_acc_st", 64'(acc_st), 64'd1);
    check("rst_acc_en", 64'(acc_en), 64'd0);
    check("rst_acc_in1", 64'(acc_in1), 64'd0);
    rstn = 1'b1;
    tick();

    // len=3 back-to-back
    start = 1'b1; len = 8'd3; exp_q.push_back(36'h35);
    tick();
    start = 1'b0;
    check("t1_busy", 64'(busy), 64'd1);
    psum(1'b1, 20'h5);
    check("t1_ready", 64'(bus.psum_ready), 64'd1);
    check("t1_in1", 64'(acc_in1), 64'h5);
    tick();
    psum(1'b1, 20'h10);
    tick();
    psum(1'b1, 20'h20);
    tick();
    psum(1'b0, '0);
    check("t1_res_valid", 64'(bus.res_valid), 64'd1);
    tick();
    check("t1_valid_drop", 64'(bus.res_valid), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_acc_clear", 64'(acc_reg), 64'd0);

    // len=2 negative sum
    start = 1'b1; len = 8'd2; exp_q.push_back(36'hFFFFFFFFE);
    tick();
    start = 1'b0;
    psum(1'b1, 20'hFFFFD);
    tick();
    psum(1'b1, 20'h1);
    tick();
    psum(1'b0, '0);
    check("t2_res_valid", 64'(bus.res_valid), 64'd1);
    tick();

    // len=4 with gaps
    start = 1'b1; len = 8'd4; exp_q.push_back(36'd10);
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      psum(gap_v[i], gap_d[i]);
      if (!gap_v[i]) check("t3_gap_in1", 64'(acc_in1), 64'd0);
      check("t3_ready", 64'(bus.psum_ready), 64'd1);
      check("t3_not_done", 64'(bus.res_valid), 64'd0);
      tick();
    end
    psum(1'b0, '0);
    check("t3_res_valid", 64'(bus.res_valid), 64'd1);
    tick();

    // len=1 with downstream backpressure
    start = 1'b1; len = 8'd1; exp_q.push_back(36'd7); bus.res_ready = 1'b0;
    tick();
    start = 1'b0;
    psum(1'b1, 20'h7);
    tick();
    psum(1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(bus.res_valid), 64'd1);
      check("t4_no_ready", 64'(bus.psum_ready), 64'd0);
      start = (i == 2);
      len = 8'd5;
      tick();
    end
    start = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_valid_drop", 64'(bus.res_valid), 64'd0);

    // len=0 goes straight to OUT with a zero result
    start = 1'b1; len = 8'd0; exp_q.push_back(36'd0);
    tick();
    start = 1'b0;
    psum(1'b1, 20'h123);
    check("t5_res_valid", 64'(bus.res_valid), 64'd1);
    check("t5_no_ready", 64'(bus.psum_ready), 64'd0);
    check("t5_in1", 64'(acc_in1), 64'd0);
    check("t5_en", 64'(acc_en), 64'd0);
    tick();
    psum(1'b0, '0);
    check("t5_idle", 64'(busy), 64'd0);

    // reset mid-job then a clean job
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    psum(1'b1, 20'd100);
    tick();
    psum(1'b1, 20'd200);
    tick();
    psum(1'b0, '0);
    rstn = 1'b0;
    tick();
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_res_valid", 64'(bus.res_valid), 64'd0);
    check("t6_acc_st", 64'(acc_st), 64'd1);
    check("t6_no_ready", 64'(bus.psum_ready), 64'd0);
    rstn = 1'b1;
    tick();
    start = 1'b1; len = 8'd1; exp_q.push_back(36'd9);
    tick();
    start = 1'b0;
    psum(1'b1, 20'd9);
    tick();
    psum(1'b0, '0);
    check("t6_res_valid", 64'(bus.res_valid), 64'd1);
    tick();
    check("t6_idle", 64'(busy), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
